// File: rtl/vargen_timer.sv
// Memory-mapped 32-bit prescaled timer with compare match, one-shot/auto-reload
// modes and a sticky match flag on the picorv32-style iomem bus.
module vargen_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq_out
);

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COMPARE  = 3'd2,
        REG_COUNT    = 3'd3,
        REG_STATUS   = 3'd4
    } reg_off_e;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_AUTO = 1;
    localparam int unsigned CTRL_IRQ  = 2;

    logic                  ready_q;
    logic [31:0]           rdata_q, rdata_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           cmp_q, cmp_d;
    logic [31:0]           count_q, count_d;
    logic                  match_q, match_d;

    logic                  hit;
    logic                  wr_en;
    logic [2:0]            reg_off;
    logic                  tick;
    logic                  at_compare;
    logic                  match_set;
    logic                  match_clr;
    logic [31:0]           presc_ext;
    logic [31:0]           presc_merged;
    logic                  unused_addr_bits;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign hit              = iomem_valid && !ready_q && (iomem_addr[31:5] == BASE_ADDR[31:5]);
    assign wr_en            = hit && (iomem_wstrb != 4'b0000);
    assign reg_off          = iomem_addr[4:2];
    assign unused_addr_bits = ^iomem_addr[1:0];

    always_comb begin
        presc_ext                   = '0;
        presc_ext[PRESCALE_W-1:0]   = presc_q;
    end

    assign presc_merged = merge_bytes(presc_ext, iomem_wdata, iomem_wstrb);

    assign tick       = ctrl_q[CTRL_EN] && (pcnt_q == presc_q);
    assign at_compare = (count_q == cmp_q);
    assign match_set  = tick && at_compare;
    assign match_clr  = wr_en && (reg_off == REG_STATUS) && iomem_wstrb[0] && iomem_wdata[0];

    // Read data is captured in the hit cycle, before that cycle's write lands.
    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (reg_off)
                REG_CTRL:     rdata_d = {29'd0, ctrl_q};
                REG_PRESCALE: rdata_d = presc_ext;
                REG_COMPARE:  rdata_d = cmp_q;
                REG_COUNT:    rdata_d = count_q;
                REG_STATUS:   rdata_d = {31'd0, match_q};
                default:      rdata_d = '0;
            endcase
        end
    end

    // Timer evolution first, then software writes override it.
    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        cmp_d   = cmp_q;
        count_d = count_q;

        if (ctrl_q[CTRL_EN]) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
        end

        if (tick) begin
            if (at_compare) begin
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = '0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_en) begin
            case (reg_off)
                REG_CTRL: begin
                    if (iomem_wstrb[0]) begin
                        ctrl_d = iomem_wdata[2:0];
                        if (iomem_wdata[CTRL_EN] && !ctrl_q[CTRL_EN]) begin
                            pcnt_d = '0;
                        end
                    end
                end
                REG_PRESCALE: begin
                    presc_d = presc_merged[PRESCALE_W-1:0];
                    pcnt_d  = '0;
                end
                REG_COMPARE: begin
                    cmp_d = merge_bytes(cmp_q, iomem_wdata, iomem_wstrb);
                end
                REG_COUNT: begin
                    count_d = merge_bytes(count_q, iomem_wdata, iomem_wstrb);
                    pcnt_d  = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // A match event in the same cycle as a W1C leaves the flag set.
    assign match_d = (match_q && !match_clr) || match_set;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            ctrl_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            cmp_q   <= '0;
            count_q <= '0;
            match_q <= 1'b0;
        end else begin
            ready_q <= hit;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            cmp_q   <= cmp_d;
            count_q <= count_d;
            match_q <= match_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq_out     = match_q && ctrl_q[CTRL_IRQ];

endmodule

// File: tb/tb_vargen_timer.sv
// Self-checking bench for vargen_timer: register-access vector table, hand-built
// timing sequences, and randomized runs against closed-form timer arithmetic.
module tb_vargen_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'b0000;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic        irq_out;

    int checks = 0;
    int failures = 0;

    vargen_timer #(
        .BASE_ADDR (32'h0200_0000),
        .PRESCALE_W(16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        exp_ready;
        logic        chk_data;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; drives the request immediately.
    task automatic bus(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                       output logic [31:0] rd, output logic rdy, output logic irq_r,
                       output int lat, output logic stray);
        rdy = 1'b0; rd = '0; irq_r = 1'b0; lat = 0; stray = 1'b0;
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = ws;
        iomem_wdata = wd;
        for (int i = 1; i <= 4 && !rdy; i++) begin
            @(posedge clk); #1;
            if (iomem_ready === 1'b1) begin
                rdy = 1'b1; rd = iomem_rdata; irq_r = irq_out; lat = i;
            end else if (iomem_rdata !== 32'd0) begin
                stray = 1'b1;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        if (rdy) begin
            @(posedge clk); #1;
            if (iomem_ready !== 1'b0 || iomem_rdata !== 32'd0) stray = 1'b1;
        end
    endtask

    task automatic wr(input string name, input logic [2:0] off, input logic [3:0] ws,
                      input logic [31:0] wd, output logic irq_r);
        logic [31:0] rd; logic rdy; int lat; logic stray;
        bus(BASE + {27'd0, off, 2'b00}, ws, wd, rd, rdy, irq_r, lat, stray);
        chk({name, "_lat"}, 32'(lat), 32'd1);
        chk({name, "_pulse"}, {31'd0, stray}, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] off, input logic [31:0] exp);
        logic [31:0] rd; logic rdy; logic irq_r; int lat; logic stray;
        bus(BASE + {27'd0, off, 2'b00}, 4'b0000, 32'd0, rd, rdy, irq_r, lat, stray);
        chk({name, "_lat"}, 32'(lat), 32'd1);
        chk(name, rd, exp);
    endtask

    task automatic wait_irq(input int start, input int limit, output int n);
        n = start;
        while (irq_out !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    function automatic logic [31:0] reg_mask(input logic [2:0] off);
        case (off)
            3'd0:    return 32'h0000_0007;
            3'd1:    return 32'h0000_FFFF;
            3'd2:    return 32'hFFFF_FFFF;
            3'd3:    return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_write(input logic [31:0] old_val, input logic [31:0] wd,
                                               input logic [3:0] ws);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        logic        rdy, irq_r, stray;
        int          lat, n, n2;
        logic [31:0] model[8];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        chk("rst_irq", {31'd0, irq_out}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int o = 0; o < 8; o++)
            vecs.push_back('{BASE + 32'(o * 4), 4'h0, 32'd0, 1'b1, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h20, 4'h0, 32'd0, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{32'h0000_0100, 4'h0, 32'd0, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{32'h0000_0100, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h08, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h08, 4'hF, 32'h0000_0000, 1'b1, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h08, 4'h2, 32'hAABB_CCDD, 1'b1, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h08, 4'h0, 32'd0, 1'b1, 1'b1, 32'h0000_CC00});
        vecs.push_back('{BASE + 32'h04, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h04, 4'h0, 32'd0, 1'b1, 1'b1, 32'h0000_5678});
        vecs.push_back('{BASE + 32'h00, 4'hF, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h00, 4'h0, 32'd0, 1'b1, 1'b1, 32'h0000_0006});
        vecs.push_back('{BASE + 32'h00, 4'hF, 32'h0000_0000, 1'b1, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h14, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0});
        vecs.push_back('{BASE + 32'h14, 4'h0, 32'd0, 1'b1, 1'b1, 32'd0});
        vecs.push_back('{BASE + 32'h0C, 4'h0, 32'd0, 1'b1, 1'b1, 32'd0});

        foreach (vecs[i]) begin
            bus(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, rd, rdy, irq_r, lat, stray);
            chk($sformatf("vec%0d_ready", i), {31'd0, rdy}, {31'd0, vecs[i].exp_ready});
            chk($sformatf("vec%0d_stray", i), {31'd0, stray}, 32'd0);
            if (vecs[i].exp_ready) chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
            if (vecs[i].chk_data) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end
        chk("idle_irq", {31'd0, irq_out}, 32'd0);

        // Auto-reload: period 20 cycles, W1C, and W1C colliding with a match.
        wr("ar_pre", 3'd1, 4'hF, 32'd3, irq_r);
        wr("ar_cmp", 3'd2, 4'hF, 32'd4, irq_r);
        wr("ar_cnt", 3'd3, 4'hF, 32'd0, irq_r);
        wr("ar_ctrl", 3'd0, 4'h1, 32'd7, irq_r);
        wait_irq(1, 100, n);
        chk("ar_first_match", 32'(n), 32'd20);
        wr("ar_clr1", 3'd4, 4'h1, 32'd1, irq_r);
        chk("ar_clr1_irq", {31'd0, irq_r}, 32'd0);
        wait_irq(n + 2, 100, n);
        chk("ar_second_match", 32'(n), 32'd40);
        wr("ar_clr2", 3'd4, 4'h1, 32'd1, irq_r);
        chk("ar_clr2_irq", {31'd0, irq_r}, 32'd0);
        n = n + 2;
        while (n < 59) begin @(posedge clk); #1; n++; end
        wr("ar_clr_collide", 3'd4, 4'h1, 32'd1, irq_r);
        chk("ar_collide_irq", {31'd0, irq_r}, 32'd1);
        rd_chk("ar_collide_status", 3'd4, 32'd1);
        wr("ar_stop", 3'd0, 4'h1, 32'd0, irq_r);
        wr("ar_clr3", 3'd4, 4'h1, 32'd1, irq_r);
        chk("ar_stop_irq", {31'd0, irq_out}, 32'd0);

        // One-shot without IRQ_EN.
        wr("os_pre", 3'd1, 4'hF, 32'd0, irq_r);
        wr("os_cmp", 3'd2, 4'hF, 32'd2, irq_r);
        wr("os_cnt", 3'd3, 4'hF, 32'd0, irq_r);
        wr("os_ctrl", 3'd0, 4'h1, 32'd1, irq_r);
        repeat (5) @(posedge clk);
        #1;
        chk("os_irq", {31'd0, irq_out}, 32'd0);
        rd_chk("os_status", 3'd4, 32'd1);
        rd_chk("os_ctrl_rd", 3'd0, 32'd0);
        rd_chk("os_count", 3'd3, 32'd2);
        repeat (4) @(posedge clk);
        #1;
        rd_chk("os_count_hold", 3'd3, 32'd2);
        wr("os_clr", 3'd4, 4'h1, 32'd1, irq_r);

        // COUNT wraps through zero before matching.
        wr("wr_cnt", 3'd3, 4'hF, 32'hFFFF_FFFE, irq_r);
        wr("wr_cmp", 3'd2, 4'hF, 32'd5, irq_r);
        wr("wr_ctrl", 3'd0, 4'h1, 32'd5, irq_r);
        wait_irq(1, 100, n);
        chk("wrap_match", 32'(n), 32'd8);
        rd_chk("wrap_count", 3'd3, 32'd5);
        rd_chk("wrap_ctrl", 3'd0, 32'd4);
        wr("wrap_off", 3'd0, 4'h1, 32'd0, irq_r);
        wr("wrap_clr", 3'd4, 4'h1, 32'd1, irq_r);

        // Randomized register file traffic with the timer stopped.
        for (int o = 0; o < 4; o++) wr("rr_init", 3'(o), 4'hF, 32'd0, irq_r);
        for (int o = 0; o < 8; o++) model[o] = 32'd0;
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  off;
            logic [3:0]  ws;
            logic [31:0] wd;
            off = 3'($urandom_range(0, 7));
            ws  = 4'($urandom_range(0, 15));
            wd  = $urandom();
            if (off == 3'd0) wd[0] = 1'b0;
            if (ws == 4'h0) begin
                rd_chk($sformatf("rr_rd%0d_off%0d", k, off), off, model[off]);
            end else begin
                wr($sformatf("rr_wr%0d", k), off, ws, wd, irq_r);
                model[off] = lane_write(model[off], wd, ws) & reg_mask(off);
            end
        end
        for (int o = 0; o < 8; o++) rd_chk($sformatf("rr_final_off%0d", o), 3'(o), model[o]);

        // Randomized timer runs: match time = (COMPARE-COUNT0+1)*(PRESCALE+1).
        for (int k = 0; k < 12; k++) begin
            int unsigned p, c, c0, auto_rl, t, first;
            p  = $urandom_range(0, 3);
            c  = $urandom_range(0, 6);
            c0 = $urandom_range(0, c);
            auto_rl = $urandom_range(0, 1);
            t = (c + 1) * (p + 1);
            first = (c - c0 + 1) * (p + 1);
            wr("rt_off", 3'd0, 4'h1, 32'd0, irq_r);
            wr("rt_clr", 3'd4, 4'h1, 32'd1, irq_r);
            wr("rt_pre", 3'd1, 4'hF, 32'(p), irq_r);
            wr("rt_cmp", 3'd2, 4'hF, 32'(c), irq_r);
            wr("rt_cnt", 3'd3, 4'hF, 32'(c0), irq_r);
            wr("rt_ctrl", 3'd0, 4'h1, 32'h5 | 32'(auto_rl << 1), irq_r);
            wait_irq(1, 200, n);
            chk($sformatf("rt%0d_first_p%0d_c%0d_c0%0d", k, p, c, c0), 32'(n), 32'(first));
            if (auto_rl == 1 && t >= 3) begin
                wr("rt_reclr", 3'd4, 4'h1, 32'd1, irq_r);
                chk($sformatf("rt%0d_clr_irq", k), {31'd0, irq_r}, 32'd0);
                wait_irq(n + 2, n + 200, n2);
                chk($sformatf("rt%0d_period", k), 32'(n2 - n), 32'(t));
            end else if (auto_rl == 0) begin
                rd_chk($sformatf("rt%0d_os_ctrl", k), 3'd0, 32'd4);
                rd_chk($sformatf("rt%0d_os_count", k), 3'd3, 32'(c));
            end
        end
        wr("end_off", 3'd0, 4'h1, 32'd0, irq_r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
